// File: rtl/memory1_stage.sv
// First memory stage: registers the execute result, checks alignment and issues one dcache request per load/store.
// Optional build macro MEM1_ALIGN_CHECK_EN enables misaligned-access (ALE) detection; undefined issues misaligned accesses as-is.
module memory1_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_stall,
    input  logic                  is_flush,
    input  logic                  in_valid,
    input  logic                  in_is_mem,
    input  logic                  in_is_store,
    input  logic [1:0]            in_byte_type,
    input  logic                  in_is_signed,
    input  logic [ADDR_WIDTH-1:0] in_ex_out,
    input  logic [31:0]           in_st_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_is_wr_rd,
    output logic                  dc_req_valid,
    input  logic                  dc_req_ready,
    output logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_we,
    output logic [3:0]            dc_req_wstrb,
    output logic [31:0]           dc_req_wdata,
    output logic                  dcache_req_stall,
    output logic                  out_valid,
    output logic                  out_is_mem,
    output logic [1:0]            out_byte_en,
    output logic [1:0]            out_byte_type,
    output logic                  out_is_signed,
    output logic [ADDR_WIDTH-1:0] out_ex_out,
    output logic [4:0]            out_rd,
    output logic                  out_is_wr_rd,
    output logic                  out_ale,
    output logic                  fwd_valid,
    output logic [4:0]            fwd_idx,
    output logic [31:0]           fwd_data,
    output logic                  fwd_is_load
);

`ifdef MEM1_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK_EN = 1'b1;
`else
    localparam bit ALIGN_CHECK_EN = 1'b0;
`endif

    localparam logic [1:0] BT_BYTE = 2'd0;
    localparam logic [1:0] BT_HALF = 2'd1;
    localparam logic [1:0] BT_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                  state;
    logic                    r_valid;
    logic                    r_is_mem;
    logic                    r_is_store;
    logic [1:0]              r_byte_type;
    logic                    r_is_signed;
    logic [ADDR_WIDTH-1:0]   r_ex_out;
    logic [31:0]             r_st_data;
    logic [4:0]              r_rd;
    logic                    r_is_wr_rd;
    logic                    r_misaligned;
    logic                    in_misaligned;

    function automatic logic misaligned(input logic [1:0] bt, input logic [1:0] a);
        return ALIGN_CHECK_EN && (((bt == BT_HALF) && a[0]) || ((bt == BT_WORD) && (a != 2'b00)));
    endfunction

    assign in_misaligned = misaligned(in_byte_type, in_ex_out[1:0]);
    assign r_misaligned  = misaligned(r_byte_type, r_ex_out[1:0]);

    // A request is owed only for aligned memory ops; DONE remembers an accept that happened under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_valid     <= 1'b0;
            r_is_mem    <= 1'b0;
            r_is_store  <= 1'b0;
            r_byte_type <= 2'd0;
            r_is_signed <= 1'b0;
            r_ex_out    <= '0;
            r_st_data   <= 32'd0;
            r_rd        <= 5'd0;
            r_is_wr_rd  <= 1'b0;
        end else if (is_flush) begin
            r_valid <= 1'b0;
            state   <= IDLE;
        end else if (!is_stall) begin
            r_valid     <= in_valid;
            r_is_mem    <= in_is_mem;
            r_is_store  <= in_is_store;
            r_byte_type <= in_byte_type;
            r_is_signed <= in_is_signed;
            r_ex_out    <= in_ex_out;
            r_st_data   <= in_st_data;
            r_rd        <= in_rd;
            r_is_wr_rd  <= in_is_wr_rd;
            state       <= (in_valid && in_is_mem && !in_misaligned) ? REQ : IDLE;
        end else if (state == REQ && dc_req_ready) begin
            state <= DONE;
        end
    end

    assign dc_req_valid     = (state == REQ) && !is_flush;
    assign dcache_req_stall = (state == REQ) && !dc_req_ready && !is_flush;
    assign dc_req_addr      = {r_ex_out[ADDR_WIDTH-1:2], 2'b00};
    assign dc_req_we        = r_is_store;

    // Lane replication lets the cache take wdata as-is and pick bytes by wstrb.
    always_comb begin
        dc_req_wstrb = 4'b0000;
        dc_req_wdata = r_st_data;
        case (r_byte_type)
            BT_BYTE: begin
                dc_req_wdata = {4{r_st_data[7:0]}};
                dc_req_wstrb = 4'b0001 << r_ex_out[1:0];
            end
            BT_HALF: begin
                dc_req_wdata = {2{r_st_data[15:0]}};
                dc_req_wstrb = r_ex_out[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dc_req_wdata = r_st_data;
                dc_req_wstrb = 4'b1111;
            end
        endcase
        if (!r_is_store) begin
            dc_req_wstrb = 4'b0000;
        end
    end

    assign out_ale       = r_valid && r_is_mem && r_misaligned;
    assign out_valid     = r_valid && !is_flush;
    assign out_is_mem    = out_valid && r_is_mem && !out_ale;
    assign out_byte_en   = r_ex_out[1:0];
    assign out_byte_type = r_byte_type;
    assign out_is_signed = r_is_signed;
    assign out_ex_out    = r_ex_out;
    assign out_rd        = r_rd;
    assign out_is_wr_rd  = r_is_wr_rd && out_valid && !out_ale;

    assign fwd_valid   = out_is_wr_rd;
    assign fwd_idx     = r_rd;
    assign fwd_data    = 32'(r_ex_out);
    assign fwd_is_load = out_is_mem && !r_is_store;

endmodule
